// File: rtl/sync_down_counter.sv
// Programmable down-counter/timer on T flip-flops with one-shot or auto-reload
// terminal count; tc is a registered one-cycle pulse coincident with q reading 0.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] t;
  logic             q_is_zero;
  logic             q_is_one;

  // Stage i toggles when every lower bit is 0 (the borrow ripples through).
  always_comb begin : toggle_gen
    logic borrow;
    borrow = 1'b1;
    t      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]   = borrow;
      borrow = borrow & ~q[i];
    end
  end

  assign q_is_zero = (q == '0);
  assign q_is_one  = (q == WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= '0;
      tc         <= 1'b0;
      busy       <= 1'b0;
      reload_reg <= '0;
      state      <= IDLE;
    end else begin
      tc <= 1'b0;
      if (load) begin
        reload_reg <= load_val;
        q          <= load_val;
        if (load_val != '0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= DONE;
          busy  <= 1'b0;
        end
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              if (q_is_zero) begin
                // Only reached in auto-reload: the 0 cycle completes the period.
                q <= reload_reg;
              end else begin
                q <= q ^ t;
                if (q_is_one) begin
                  tc <= 1'b1;
                  if (!auto_reload) begin
                    state <= DONE;
                    busy  <= 1'b0;
                  end
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter: vector table plus hand sequences for reset and long counts.
module tb_sync_down_counter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       ar;
    logic [3:0] exp_q;
    logic       exp_tc;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input int eq, input int etc, input int ebusy);
    check({name, ".q"}, int'(q), eq);
    check({name, ".tc"}, int'(tc), etc);
    check({name, ".busy"}, int'(busy), ebusy);
  endtask

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic l, input logic [3:0] lv, input logic e, input logic ar);
    @(negedge clk);
    load        = l;
    load_val    = lv;
    en          = e;
    auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic l, logic [3:0] lv, logic e, logic ar,
                              logic [3:0] eq, logic etc, logic eb);
    vec_t v;
    v.load = l; v.load_val = lv; v.en = e; v.ar = ar;
    v.exp_q = eq; v.exp_tc = etc; v.exp_busy = eb;
    return v;
  endfunction

  initial begin
    // one-shot from 5
    vecs.push_back(mk(1, 5, 0, 0, 5, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // enable gating from 3
    vecs.push_back(mk(1, 3, 0, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0));
    // auto-reload from 2, period 3
    vecs.push_back(mk(1, 2, 0, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1));
    // load beats en at q=1, suppressing tc
    vecs.push_back(mk(1, 7, 0, 0, 7, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 6, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 5, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 4, 1, 0, 4, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1));
    // load 0 goes straight to DONE, no tc, no wrap
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));

    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
    #2;
    check_out("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // en without a prior load must not move q out of IDLE
    step(0, 0, 1, 0);
    check_out("idle_en", 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].ar);
      check_out($sformatf("vec%0d", i), int'(vecs[i].exp_q), int'(vecs[i].exp_tc),
                int'(vecs[i].exp_busy));
    end

    // one-shot hold: DONE keeps q at 0 with en high for 10 cycles
    step(1, 5, 0, 0);
    for (int i = 4; i >= 0; i--) begin
      step(0, 0, 1, 0);
      check_out($sformatf("os5_q%0d", i), i, (i == 0) ? 1 : 0, (i == 0) ? 0 : 1);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 0);
      check_out($sformatf("os5_hold%0d", i), 0, 0, 0);
    end

    // full-scale count from 15
    step(1, 15, 0, 0);
    check_out("l15_load", 15, 0, 1);
    for (int i = 14; i >= 0; i--) begin
      step(0, 0, 1, 0);
      check_out($sformatf("l15_q%0d", i), i, (i == 0) ? 1 : 0, (i == 0) ? 0 : 1);
    end

    // asynchronous reset mid-RUN
    step(1, 9, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check_out("rst_pre", 6, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_async", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      check_out($sformatf("rst_after%0d", i), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Programmable synchronous down-counter/timer built from T flip-flop stages.
- It is the count-down counterpart of the team's T-flop up-counter.
- Loads a start value, decrements on enabled cycles, and flags terminal count with a one-cycle pulse.
- Used as a delay/period timer beside the up-counter in the same clock domain. It supports one-shot and auto-reload modes.

Parameters:
WIDTH, 4, counter width in bits (minimum 2).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  start value captured on load.
en  input  1  count enable; one decrement per enabled cycle.
auto_reload  input  1  1 = reload from stored start value after reaching 0; 0 = one-shot.
q  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle wide.
busy  output  1  high while the FSM is in RUN.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - On rst, regardless of clk: q=0, tc=0, busy=0, reload register=0, FSM=IDLE.
- Datapath:
  - q is held in WIDTH T flip-flops.
  - Decrement uses toggle enables: t[0]=1 and t[i]=AND of ~q[j] for j<i.
  - Load and reload force q through a synchronous parallel path, not through the toggles.
  - Width is fixed at WIDTH. No arithmetic carry leaves the block.
- Internal register: reload_reg (WIDTH) captures load_val on every load.
- FSM states: IDLE, RUN, DONE.
  - IDLE: q holds, busy=0. load with load_val!=0 -> RUN, q<=load_val. load with load_val==0 -> DONE, q<=0, no tc.
  - RUN: busy=1.
    - en=0: q holds.
    - en=1 and q>1: q<=q-1.
    - en=1 and q==1: q<=0, and tc=1 in the cycle q first reads 0. If auto_reload=0 -> DONE; if auto_reload=1 stay in RUN.
    - en=1 and q==0 (only reachable in auto-reload): q<=reload_reg, no tc. The period is therefore reload_reg+1 enabled cycles.
  - DONE: q=0, busy=0. q never wraps to all-ones. Only load leaves DONE, with the same rules as in IDLE.
- Priority: rst > load > en.
  - load in any state, including mid-count, restarts from load_val and suppresses any tc that would have fired that cycle.
  - Simultaneous load and en: the load wins and no decrement occurs that cycle.
- auto_reload is sampled on the cycle q goes 1->0. Changing it mid-count has no other effect.
- tc is high for exactly one cycle per terminal event and is never asserted by load or reset.
- Latency: load_val appears on q one cycle after load. The decrement appears one cycle after en.
- Reset mid-operation: outputs clear immediately (asynchronously). The next operation requires a new load.

Test Plan:
- Reset mid-RUN: WIDTH=4, load 9, count 3 cycles, assert rst asynchronously between edges -> q=0, busy=0, tc=0 immediately. With en held high and no load -> q stays 0 and no wrap to 15.
- One-shot: load 5, auto_reload=0, en=1 continuous -> q=5,4,3,2,1,0 on successive cycles. tc=1 only in the cycle q=0, then busy=0 and q holds 0 for 10 more cycles.
- Enable gating: load 3, toggle en 1,0,0,1,1 -> q=3,2,2,2,1,0. tc fires on the q=0 cycle.
- Auto-reload: load 2, auto_reload=1, en=1 for 9 cycles -> q=2,1,0,2,1,0,2,1,0. tc is high on each q=0 cycle (period 3) and busy stays 1.
- Load priority and edge values:
  - Load 7, then at q=1 assert load with load_val=4 and en=1 -> q=4 next cycle and no tc that cycle.
  - Load 0 -> DONE, busy=0, no tc.
  - Load 15 -> counts to 0 in 15 enabled cycles.
